cache_refill: RTL and testbench

//   Page-fill engine behind the 4-slot page cache. On a miss the cache FSM
//   (refresh states 4'b1100..4'b1111) hands it a 14-bit page number; this

---
 rtl/cache_refill.sv | 144 ++++++++++++++
 tb/tb_cache_refill.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// cache_refill: page-fill engine for the 4-slot page cache.
// On a miss it picks a round-robin victim slot and copies one page from
// backing memory into that SRAM slot, one byte per fetch/write pair. When
// the last byte is in, it installs the new tag and pulses done.
module cache_refill #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned PAGE_BITS = 10,
   parameter int unsigned SLOT_BITS = 2
) (
   input  logic                           fpgaClk,
   input  logic                           fpgaRst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_W-PAGE_BITS-1:0]    req_page,
   output logic                           mem_rd,
   output logic [ADDR_W-1:0]              mem_addr,
   input  logic                           mem_valid,
   input  logic [7:0]                     mem_data,
   output logic                           sram_ce,
   output logic                           sram_we,
   output logic [SLOT_BITS+PAGE_BITS-1:0] sram_addr,
   output logic [7:0]                     sram_wdata,
   output logic                           tag_we,
   output logic [SLOT_BITS-1:0]           tag_slot,
   output logic [ADDR_W-PAGE_BITS-1:0]    tag_page,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned PW = ADDR_W - PAGE_BITS;
   localparam int unsigned SW = SLOT_BITS + PAGE_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_COMMIT
   } state_t;

   state_t                 state_q;
   logic [PAGE_BITS-1:0]   offset_q;
   logic [PAGE_BITS-1:0]   offset_d;
   logic [SLOT_BITS-1:0]   victim_q;
   logic                   req_ready_q;
   logic                   mem_rd_q;
   logic [ADDR_W-1:0]      mem_addr_q;
   logic                   sram_ce_q;
   logic                   sram_we_q;
   logic [SW-1:0]          sram_addr_q;
   logic [7:0]             sram_wdata_q;
   logic                   tag_we_q;
   logic [SLOT_BITS-1:0]   tag_slot_q;
   logic [PW-1:0]          tag_page_q;
   logic                   busy_q;
   logic                   done_q;

   assign offset_d = offset_q + 1'b1;

   // Fill FSM; every output is loaded alongside the state it belongs to.
   // tag_slot_q/tag_page_q double as the latched fill slot and page.
   always_ff @(posedge fpgaClk) begin
      if (!fpgaRst_n) begin
         state_q      <= S_IDLE;
         offset_q     <= '0;
         victim_q     <= '0;
         req_ready_q  <= 1'b1;
         mem_rd_q     <= 1'b0;
         mem_addr_q   <= '0;
         sram_ce_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         tag_we_q     <= 1'b0;
         tag_slot_q   <= '0;
         tag_page_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  tag_page_q  <= req_page;
                  tag_slot_q  <= victim_q;
                  offset_q    <= '0;
                  mem_rd_q    <= 1'b1;
                  mem_addr_q  <= {req_page, {PAGE_BITS{1'b0}}};
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (mem_valid) begin
                  mem_rd_q     <= 1'b0;
                  sram_wdata_q <= mem_data;
                  sram_ce_q    <= 1'b1;
                  sram_we_q    <= 1'b1;
                  sram_addr_q  <= {tag_slot_q, offset_q};
                  state_q      <= S_WRITE;
               end
            end
            S_WRITE: begin
               sram_ce_q <= 1'b0;
               sram_we_q <= 1'b0;
               if (offset_q == '1) begin
                  tag_we_q <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= S_COMMIT;
               end else begin
                  offset_q   <= offset_d;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= {tag_page_q, offset_d};
                  state_q    <= S_FETCH;
               end
            end
            S_COMMIT: begin
               tag_we_q    <= 1'b0;
               done_q      <= 1'b0;
               victim_q    <= victim_q + 1'b1;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;
   assign sram_ce    = sram_ce_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign tag_we     = tag_we_q;
   assign tag_slot   = tag_slot_q;
   assign tag_page   = tag_page_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: a behavioural backing memory answers
// reads, expected SRAM writes are queued per request and popped as the DUT
// writes them, and fill latency / tag install are checked per request.
module tb_cache_refill;

   logic        clk;
   logic        fpgaRst_n;
   logic        req_valid;
   logic        req_ready;
   logic [13:0] req_page;
   logic        mem_rd;
   logic [23:0] mem_addr;
   logic        mem_valid;
   logic [7:0]  mem_data;
   logic        sram_ce;
   logic        sram_we;
   logic [11:0] sram_addr;
   logic [7:0]  sram_wdata;
   logic        tag_we;
   logic [1:0]  tag_slot;
   logic [13:0] tag_page;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          rd_cycles = 0;
   int          done_cnt = 0;
   int          tagwe_cnt = 0;
   logic [13:0] cur_page = '0;
   int          mem_wait = 0;
   int          data_mode = 0;
   bit          glitch = 1'b0;
   int          wcnt = 0;

   cache_refill #(.ADDR_W(24), .PAGE_BITS(10), .SLOT_BITS(2)) dut (
      .fpgaClk   (clk),
      .fpgaRst_n (fpgaRst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_page  (req_page),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .sram_ce   (sram_ce),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .tag_we    (tag_we),
      .tag_slot  (tag_slot),
      .tag_page  (tag_page),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] mdata(input logic [23:0] a, input int m);
      if (m == 0) return a[7:0];
      return a[7:0] ^ a[17:10] ^ 8'h5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Backing memory: answers a read after mem_wait idle cycles; in glitch
   // mode it also raises mem_valid with junk data while no read is pending.
   initial begin
      mem_valid = 1'b0;
      mem_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_rd) begin
            if (wcnt >= mem_wait) begin
               mem_valid = 1'b1;
               mem_data  = mdata(mem_addr, data_mode);
               wcnt      = 0;
            end else begin
               mem_valid = 1'b0;
               wcnt++;
            end
         end else begin
            wcnt      = 0;
            mem_valid = glitch;
            mem_data  = 8'hEE;
         end
      end
   end

   // Output monitor: scoreboard pops on every SRAM write, read address
   // must track the number of bytes already written.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (done)   done_cnt++;
         if (tag_we) tagwe_cnt++;
         if (sram_we) begin
            check("sram_ce_with_we", sram_ce, 1);
            check("rd_during_we", mem_rd, 0);
            check("write_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("sram_addr", sram_addr, e.addr);
               check("sram_wdata", sram_wdata, e.data);
            end
            wr_cnt++;
         end
         if (mem_rd) begin
            rd_cycles++;
            check("mem_addr", mem_addr, {cur_page, wr_cnt[9:0]});
         end
      end
   end

   task automatic start_fill(input logic [13:0] page, input logic [1:0] slot);
      @(negedge clk);
      check("ready_before_req", req_ready, 1);
      cur_page  = page;
      wr_cnt    = 0;
      rd_cycles = 0;
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] off;
         off = i[9:0];
         sb.push_back('{addr: {slot, off}, data: mdata({page, off}, data_mode)});
      end
      req_valid = 1'b1;
      req_page  = page;
   endtask

   task automatic run_fill(input logic [13:0] page, input logic [1:0] slot,
                           input int exp_cyc, input bit hold);
      int cyc;
      bit got;
      start_fill(page, slot);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1 && !hold) req_valid = 1'b0;
         if (done) got = 1'b1;
      end
      check("done_seen", got, 1);
      check("latency", cyc, exp_cyc);
      check("tag_we_at_done", tag_we, 1);
      check("tag_slot", tag_slot, slot);
      check("tag_page", tag_page, page);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("tag_we_one_cycle", tag_we, 0);
      check("ready_after", req_ready, 1);
      check("busy_after", busy, 0);
      check("write_count", wr_cnt, 1024);
      check("sb_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      fpgaRst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      fpgaRst_n = 1'b1;
   endtask

   initial begin
      int d0;
      int t0;
      int n;
      fpgaRst_n = 1'b0;
      req_valid = 1'b0;
      req_page  = '0;

      // 1: reset state
      do_reset();
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_sram_ce", sram_ce, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_tag_we", tag_we, 0);
      check("rst_done", done, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_sram_addr", sram_addr, 0);
      check("rst_sram_wdata", sram_wdata, 0);
      check("rst_tag_slot", tag_slot, 0);
      check("rst_tag_page", tag_page, 0);

      // 2: single zero-wait fill, data = offset
      data_mode = 0;
      run_fill(14'h0005, 2'd0, 2049, 1'b0);

      // 3: round-robin victim selection with wrap
      do_reset();
      data_mode = 1;
      run_fill(14'h0001, 2'd0, 2049, 1'b0);
      run_fill(14'h0002, 2'd1, 2049, 1'b0);
      run_fill(14'h0003, 2'd2, 2049, 1'b0);
      run_fill(14'h0004, 2'd3, 2049, 1'b0);
      run_fill(14'h0009, 2'd0, 2049, 1'b0);

      // 4: three wait cycles per byte
      mem_wait = 3;
      run_fill(14'h2A5B, 2'd1, 5121, 1'b0);
      check("rd_cycles_wait", rd_cycles, 4096);
      mem_wait = 0;

      // 5: reset during byte 300 aborts the fill
      start_fill(14'h0007, 2'd2);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (wr_cnt < 300 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("reached_byte300", (wr_cnt >= 300) ? 1 : 0, 1);
      d0 = done_cnt;
      t0 = tagwe_cnt;
      fpgaRst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_ready", req_ready, 1);
      check("abort_mem_rd", mem_rd, 0);
      check("abort_sram_we", sram_we, 0);
      check("abort_tag_we", tag_we, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      fpgaRst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_no_tag", tagwe_cnt - t0, 0);
      sb.delete();
      run_fill(14'h0008, 2'd0, 2049, 1'b0);

      // 6: req_valid held and stray mem_valid are ignored
      glitch = 1'b1;
      d0 = done_cnt;
      run_fill(14'h3FFF, 2'd1, 2049, 1'b1);
      repeat (4) @(negedge clk);
      glitch = 1'b0;
      check("single_done", done_cnt - d0, 1);
      check("idle_after_hold", busy, 0);
      check("no_extra_writes", wr_cnt, 1024);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
